data_memory_responder: RTL and testbench

- Backing main memory that answers block refill and write-back requests from the data cache controller.
- Sits on the cache's memory-side bus and is the responder end of the READ/WRITE/BUSYWAIT handshake the cache initiates.
- Models a fixed multi-cycle access latency, so cache miss stalls propagate to the pipeline through the busywait chain.
- Transfers one 128-bit block (four 32-bit words) per request.

---
 rtl/data_memory_responder.sv | 127 ++++++++++++
 tb/tb_data_memory_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Block-granular backing memory answering cache refill/write-back requests with a fixed access latency.
// Optional DATA_MEMORY_PERF_CNT_EN adds completed read/write counters.
module data_memory_responder #(
    parameter int BLOCK_ADDR_W = 28,
    parameter int DEPTH        = 256,
    parameter int LATENCY      = 5
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    READ,
    input  logic                    WRITE,
    input  logic [BLOCK_ADDR_W-1:0] ADDRESS,
    input  logic [127:0]            WRITEDATA,
    output logic [127:0]            READDATA,
    output logic                    BUSYWAIT,
    output logic                    PROTO_ERR
`ifdef DATA_MEMORY_PERF_CNT_EN
    ,
    output logic [31:0]             READ_COUNT,
    output logic [31:0]             WRITE_COUNT
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_reg;
    logic [7:0]         count_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [127:0]       wdata_reg;
    logic               write_op_reg;
    logic               proto_err_reg;

    logic               accept;
    logic               load_read;
    logic               commit;
    logic [IDX_W-1:0]   rd_idx;

    assign accept   = (state_reg == IDLE) && (READ || WRITE);
    assign BUSYWAIT = accept || (state_reg == BUSY);
    assign PROTO_ERR = proto_err_reg;

    // The array is read on the edge that enters DONE so READDATA is valid throughout DONE.
    // With LATENCY=1 that edge is the acceptance edge, so the index comes straight from ADDRESS.
    assign load_read = !RESET &&
                       ((accept && (LATENCY == 1) && !WRITE) ||
                        ((state_reg == BUSY) && (count_reg == 8'd1) && !write_op_reg));
    assign rd_idx    = (state_reg == IDLE) ? ADDRESS[IDX_W-1:0] : idx_reg;
    assign commit    = !RESET && (state_reg == DONE) && write_op_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            idx_reg       <= '0;
            wdata_reg     <= '0;
            write_op_reg  <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (READ || WRITE) begin
                        idx_reg      <= ADDRESS[IDX_W-1:0];
                        wdata_reg    <= WRITEDATA;
                        write_op_reg <= WRITE;
                        count_reg    <= LOAD;
                        if (READ && WRITE)
                            proto_err_reg <= 1'b1;
                        state_reg    <= (LATENCY == 1) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    count_reg <= count_reg - 8'd1;
                    if (count_reg == 8'd1)
                        state_reg <= DONE;
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word
            logic [31:0] mem [DEPTH];
            logic [31:0] rd_word_reg;

            always_ff @(posedge CLK) begin
                if (commit)
                    mem[idx_reg] <= wdata_reg[gi*32 +: 32];
            end

            always_ff @(posedge CLK) begin
                if (RESET)
                    rd_word_reg <= '0;
                else if (load_read)
                    rd_word_reg <= mem[rd_idx];
            end

            assign READDATA[gi*32 +: 32] = rd_word_reg;
        end
    endgenerate

`ifdef DATA_MEMORY_PERF_CNT_EN
    logic [31:0] read_count_reg;
    logic [31:0] write_count_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            read_count_reg  <= '0;
            write_count_reg <= '0;
        end else if (state_reg == DONE) begin
            if (write_op_reg)
                write_count_reg <= write_count_reg + 32'd1;
            else
                read_count_reg  <= read_count_reg + 32'd1;
        end
    end

    assign READ_COUNT  = read_count_reg;
    assign WRITE_COUNT = write_count_reg;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed scenarios plus randomized traffic
// against an array-of-blocks reference model.
module tb_data_memory_responder;

    localparam int LAT   = 5;
    localparam int DEPTH = 256;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         READ;
    logic         WRITE;
    logic [27:0]  ADDRESS;
    logic [127:0] WRITEDATA;
    logic [127:0] READDATA;
    logic         BUSYWAIT;
    logic         PROTO_ERR;
`ifdef DATA_MEMORY_PERF_CNT_EN
    logic [31:0]  READ_COUNT;
    logic [31:0]  WRITE_COUNT;
`endif

    data_memory_responder #(
        .BLOCK_ADDR_W(28),
        .DEPTH(DEPTH),
        .LATENCY(LAT)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .READ(READ),
        .WRITE(WRITE),
        .ADDRESS(ADDRESS),
        .WRITEDATA(WRITEDATA),
        .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT),
        .PROTO_ERR(PROTO_ERR)
`ifdef DATA_MEMORY_PERF_CNT_EN
        ,
        .READ_COUNT(READ_COUNT),
        .WRITE_COUNT(WRITE_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] model_mem [DEPTH];
    logic [127:0] exp_readdata;

    localparam logic [127:0] BLK_A = 128'h00000004_00000003_00000002_00000001;

    // Drives one request from an IDLE cycle (called at posedge+1) until its DONE cycle,
    // counting BUSYWAIT-high cycles and capturing READDATA in DONE. Request inputs are
    // scrambled while busy; the DUT must use its latched copies.
    task automatic run_access(input logic rd, input logic wr, input logic [27:0] addr,
                              input logic [127:0] data, input bit hold,
                              output int busy, output logic [127:0] rdata);
        READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = data;
        busy = 0;
        #1;
        while (BUSYWAIT === 1'b1 && busy < 300) begin
            busy++;
            @(posedge CLK); #1;
            ADDRESS   = 28'($urandom);
            WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
        end
        rdata = READDATA;
        $display("access rd=%0b wr=%0b addr=%h busy=%0d rdata=%h", rd, wr, addr, busy, rdata);
        if (!hold) begin
            READ = 1'b0; WRITE = 1'b0;
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset;
        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        exp_readdata = '0;
        n_checks++;
        if (BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL reset_busywait got=%b want=0", BUSYWAIT); end
        n_checks++;
        if (READDATA !== 128'h0) begin n_fail++; $display("FAIL reset_readdata got=%h want=0", READDATA); end
        n_checks++;
        if (PROTO_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err got=%b want=0", PROTO_ERR); end
        @(posedge CLK); #1;
    endtask

    task automatic test_write_read;
        int busy;
        logic [127:0] rdata;
        run_access(1'b0, 1'b1, 28'h10, BLK_A, 1'b0, busy, rdata);
        model_mem[8'h10] = BLK_A;
        n_checks++;
        if (busy != LAT) begin n_fail++; $display("FAIL write_latency got=%0d want=%0d", busy, LAT); end
        n_checks++;
        if (rdata !== exp_readdata) begin n_fail++; $display("FAIL write_keeps_readdata got=%h want=%h", rdata, exp_readdata); end
        run_access(1'b1, 1'b0, 28'h10, '0, 1'b0, busy, rdata);
        exp_readdata = BLK_A;
        n_checks++;
        if (busy != LAT) begin n_fail++; $display("FAIL read_latency got=%0d want=%0d", busy, LAT); end
        n_checks++;
        if (rdata !== BLK_A) begin n_fail++; $display("FAIL read_0x10 got=%h want=%h", rdata, BLK_A); end
    endtask

    task automatic test_alias;
        int busy;
        logic [127:0] rdata;
        run_access(1'b1, 1'b0, 28'h110, '0, 1'b0, busy, rdata);
        n_checks++;
        if (rdata !== BLK_A) begin n_fail++; $display("FAIL alias_0x110 got=%h want=%h", rdata, BLK_A); end
    endtask

    task automatic test_reset_abort;
        int busy;
        logic [127:0] rdata;
        logic [127:0] old_blk;
        old_blk = {$urandom, $urandom, $urandom, $urandom};
        run_access(1'b0, 1'b1, 28'h20, old_blk, 1'b0, busy, rdata);
        model_mem[8'h20] = old_blk;
        WRITE = 1'b1; ADDRESS = 28'h20; WRITEDATA = ~old_blk;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b1; WRITE = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        exp_readdata = '0;
        $display("abort write addr=20 with reset in cycle 3");
        n_checks++;
        if (BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL abort_busywait got=%b want=0", BUSYWAIT); end
        n_checks++;
        if (READDATA !== 128'h0) begin n_fail++; $display("FAIL abort_readdata got=%h want=0", READDATA); end
        run_access(1'b1, 1'b0, 28'h20, '0, 1'b0, busy, rdata);
        exp_readdata = old_blk;
        n_checks++;
        if (rdata !== old_blk) begin n_fail++; $display("FAIL abort_not_committed got=%h want=%h", rdata, old_blk); end
        run_access(1'b1, 1'b0, 28'h10, '0, 1'b0, busy, rdata);
        exp_readdata = model_mem[8'h10];
        n_checks++;
        if (rdata !== model_mem[8'h10]) begin n_fail++; $display("FAIL retain_after_reset got=%h want=%h", rdata, model_mem[8'h10]); end
    endtask

    task automatic test_proto_err;
        int busy;
        logic [127:0] rdata;
        logic [127:0] blk;
        blk = {$urandom, $urandom, $urandom, $urandom};
        run_access(1'b1, 1'b1, 28'h30, blk, 1'b0, busy, rdata);
        model_mem[8'h30] = blk;
        n_checks++;
        if (PROTO_ERR !== 1'b1) begin n_fail++; $display("FAIL proto_err_set got=%b want=1", PROTO_ERR); end
        n_checks++;
        if (rdata !== exp_readdata) begin n_fail++; $display("FAIL proto_is_write got=%h want=%h", rdata, exp_readdata); end
        run_access(1'b1, 1'b0, 28'h30, '0, 1'b0, busy, rdata);
        exp_readdata = blk;
        n_checks++;
        if (rdata !== blk) begin n_fail++; $display("FAIL proto_write_data got=%h want=%h", rdata, blk); end
        n_checks++;
        if (PROTO_ERR !== 1'b1) begin n_fail++; $display("FAIL proto_err_sticky got=%b want=1", PROTO_ERR); end
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        exp_readdata = '0;
        n_checks++;
        if (PROTO_ERR !== 1'b0) begin n_fail++; $display("FAIL proto_err_clear got=%b want=0", PROTO_ERR); end
    endtask

    task automatic test_hold_through_done;
        int busy;
        logic [127:0] rdata;
        run_access(1'b1, 1'b0, 28'h10, '0, 1'b1, busy, rdata);
        exp_readdata = model_mem[8'h10];
        n_checks++;
        if (busy != LAT) begin n_fail++; $display("FAIL hold_first_latency got=%0d want=%0d", busy, LAT); end
        n_checks++;
        if (BUSYWAIT !== 1'b1) begin n_fail++; $display("FAIL hold_reaccept got=%b want=1", BUSYWAIT); end
        run_access(1'b1, 1'b0, 28'h10, '0, 1'b0, busy, rdata);
        n_checks++;
        if (busy != LAT) begin n_fail++; $display("FAIL hold_second_latency got=%0d want=%0d", busy, LAT); end
        n_checks++;
        if (rdata !== model_mem[8'h10]) begin n_fail++; $display("FAIL hold_second_data got=%h want=%h", rdata, model_mem[8'h10]); end
    endtask

    task automatic test_back_to_back;
        int busy;
        logic [127:0] rdata;
        logic [127:0] blk;
        blk = {$urandom, $urandom, $urandom, $urandom};
        run_access(1'b0, 1'b1, 28'h45, blk, 1'b0, busy, rdata);
        model_mem[8'h45] = blk;
        run_access(1'b1, 1'b0, 28'h45, '0, 1'b0, busy, rdata);
        exp_readdata = blk;
        n_checks++;
        if (rdata !== blk) begin n_fail++; $display("FAIL back_to_back got=%h want=%h", rdata, blk); end
    endtask

    task automatic test_random;
        int idx_q[$];
        int busy;
        int idx;
        int gap;
        bit do_write;
        logic [27:0]  addr;
        logic [127:0] data;
        logic [127:0] rdata;
        for (int n = 0; n < 40; n++) begin
            do_write = (idx_q.size() == 0) || ($urandom_range(0, 1) == 0);
            if (do_write) begin
                idx  = int'($urandom_range(0, DEPTH - 1));
                addr = 28'(idx + DEPTH * int'($urandom_range(0, 63)));
                data = {$urandom, $urandom, $urandom, $urandom};
                run_access(1'b0, 1'b1, addr, data, 1'b0, busy, rdata);
                model_mem[int'(addr) % DEPTH] = data;
                idx_q.push_back(int'(addr) % DEPTH);
                n_checks++;
                if (busy != LAT || rdata !== exp_readdata) begin
                    n_fail++;
                    $display("FAIL rand_write got busy=%0d rdata=%h want busy=%0d rdata=%h", busy, rdata, LAT, exp_readdata);
                end
            end else begin
                idx  = idx_q[$urandom_range(0, idx_q.size() - 1)];
                addr = 28'(idx + DEPTH * int'($urandom_range(0, 63)));
                run_access(1'b1, 1'b0, addr, '0, 1'b0, busy, rdata);
                exp_readdata = model_mem[idx];
                n_checks++;
                if (busy != LAT || rdata !== exp_readdata) begin
                    n_fail++;
                    $display("FAIL rand_read got busy=%0d rdata=%h want busy=%0d rdata=%h", busy, rdata, LAT, exp_readdata);
                end
            end
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(posedge CLK); #1;
            end
        end
    endtask

`ifdef DATA_MEMORY_PERF_CNT_EN
    task automatic test_perf_counters;
        int busy;
        logic [127:0] rdata;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        exp_readdata = '0;
        n_checks++;
        if (READ_COUNT !== 32'd0 || WRITE_COUNT !== 32'd0) begin
            n_fail++; $display("FAIL perf_reset got=%0d/%0d want=0/0", READ_COUNT, WRITE_COUNT);
        end
        for (int k = 0; k < 2; k++)
            run_access(1'b0, 1'b1, 28'(8'h50 + k), {4{$urandom}}, 1'b0, busy, rdata);
        for (int k = 0; k < 3; k++)
            run_access(1'b1, 1'b0, 28'h10, '0, 1'b0, busy, rdata);
        n_checks++;
        if (READ_COUNT !== 32'd3 || WRITE_COUNT !== 32'd2) begin
            n_fail++; $display("FAIL perf_counts got=%0d/%0d want=3/2", READ_COUNT, WRITE_COUNT);
        end
        force dut.read_count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.read_count_reg;
        run_access(1'b1, 1'b0, 28'h10, '0, 1'b0, busy, rdata);
        n_checks++;
        if (READ_COUNT !== 32'd0) begin n_fail++; $display("FAIL perf_wrap got=%h want=0", READ_COUNT); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_alias();
        test_reset_abort();
        test_proto_err();
        test_hold_through_done();
        test_back_to_back();
        test_random();
`ifdef DATA_MEMORY_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
